// File: rtl/csi_rx_lane_deskew_if.sv
// Lane-side bus of the CSI-2 lane deskew block.
// Carries unaligned per-lane bytes in and the lane-aligned word out.
interface csi_rx_lane_deskew_if #(
  parameter int NUM_LANE = 4
);
  logic [NUM_LANE-1:0][7:0] word_in;
  logic [NUM_LANE-1:0]      valid_in;
  logic [NUM_LANE-1:0][7:0] word_out;
  logic                     valid_out;

  modport master (
    output word_in,
    output valid_in,
    input  word_out,
    input  valid_out
  );

  modport slave (
    input  word_in,
    input  valid_in,
    output word_out,
    output valid_out
  );
endinterface

// File: rtl/csi_rx_lane_deskew.sv
// Multi-lane word deskew for the CSI-2 receive path: measures inter-lane skew at
// packet start, locks a delay tap per lane and reports skew violations.
module csi_rx_lane_deskew #(
  parameter  int NUM_LANE  = 4,
  parameter  int MAX_SKEW  = 3,
  parameter  int ERR_CNT_W = 16,
  localparam int TW        = $clog2(MAX_SKEW + 1)
) (
  input  logic                        byte_clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        packet_done,
  input  logic                        wait_for_sync,
  csi_rx_lane_deskew_if.slave         bus,
  output logic                        packet_done_out,
  output logic [NUM_LANE-1:0][TW-1:0] taps_out,
  output logic                        skew_err,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t state_q;
  state_t state_d;

  // The word line is one stage deeper than the valid history so the word seen on
  // the lock cycle (the header) is still selectable once the state register says LOCKED.
  logic [NUM_LANE-1:0][7:0] word_dly  [1:MAX_SKEW+1];
  logic [NUM_LANE-1:0]      valid_dly [1:MAX_SKEW];

  logic [NUM_LANE-1:0][TW-1:0] taps_q;
  logic [NUM_LANE-1:0][TW-1:0] tap_meas;
  logic [NUM_LANE-1:0]         lane_overrun;
  logic [NUM_LANE-1:0][7:0]    word_sel;
  logic                        run_ok;
  logic                        all_valid;
  logic                        lock_cond;
  logic                        lock_now;
  logic                        violation;

  always_ff @(posedge byte_clock) begin
    word_dly[1]  <= bus.word_in;
    valid_dly[1] <= bus.valid_in;
    for (int k = 2; k <= MAX_SKEW + 1; k++) begin
      word_dly[k] <= word_dly[k-1];
    end
    for (int k = 2; k <= MAX_SKEW; k++) begin
      valid_dly[k] <= valid_dly[k-1];
    end
  end

  // A lane's tap is how long it has already been valid; a lane valid for more than
  // MAX_SKEW cycles without the others joining cannot be compensated.
  always_comb begin
    tap_meas     = '0;
    lane_overrun = '0;
    run_ok       = 1'b1;
    for (int i = 0; i < NUM_LANE; i++) begin
      run_ok = 1'b1;
      for (int k = 1; k <= MAX_SKEW; k++) begin
        run_ok = run_ok & valid_dly[k][i];
        if (run_ok) begin
          tap_meas[i] = TW'(k);
        end
      end
      lane_overrun[i] = bus.valid_in[i] & run_ok;
    end
    if (NUM_LANE == 1) begin
      tap_meas     = '0;
      lane_overrun = '0;
    end
  end

  assign all_valid = &bus.valid_in;
  assign lock_cond = all_valid & wait_for_sync;
  assign violation = (state_q == SEARCH) & ~all_valid & (|lane_overrun);

  assign packet_done_out = ~reset & (packet_done | violation);

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lock_now = 1'b0;
    if (enable) begin
      case (state_q)
        SEARCH: begin
          if (lock_cond) begin
            state_d  = LOCKED;
            lock_now = 1'b1;
          end
        end
        LOCKED: begin
          if (packet_done) begin
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      taps_q   <= '0;
      skew_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      skew_err <= enable & violation;
      if (lock_now) begin
        taps_q <= tap_meas;
      end
      if (enable && violation && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign taps_out = taps_q;

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      for (int k = 0; k <= MAX_SKEW; k++) begin
        if (taps_q[i] == TW'(k)) begin
          word_sel[i] = word_dly[k+1][i];
        end
      end
    end
  end

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      bus.word_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= (state_q == LOCKED);
      if (state_q == LOCKED) begin
        bus.word_out <= word_sel;
      end
    end
  end

endmodule
